rv_mc_ctrl: RTL

Multicycle control unit for the RV32I core, replacing the single-cycle combinational decoder with a state machine that sequences one instruction over several cycles on a shared instruction/data memory port. It drives datapath mux selects, register-file and memory enables, and a ready/valid memory handshake. It also adds:
- a bus-timeout watchdog;
- illegal-instruction trapping;
- an optional multi-cycle M-extension hand-off;
- a retired-instruction counter.

---
 rtl/rv_mc_pkg.sv | 91 +++++++++
 rtl/rv_mc_watchdog.sv | 35 +++
 rtl/rv_mc_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_pkg.sv
// Shared state, opcode, mux-select and trap-cause encodings for the multicycle control unit.
// Latency: none (types, constants and a pure branch-condition helper).
// Backpressure: none.
package rv_mc_pkg;

   typedef enum logic [4:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JALR,
      S_JUMP,
      S_LUI,
      S_AUIPC,
      S_MULDIV,
      S_MDWB,
      S_TRAP
   } state_t;

   // RV32I major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU input A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU input B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Immediate format
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // funct3 010/011 are not defined branch conditions
   function automatic logic branch_legal(input logic [2:0] funct3);
      return (funct3[2:1] != 2'b01);
   endfunction

   // funct3[2:1] picks the flag, funct3[0] inverts it; undefined encodings never take
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       negative,
                                         input logic       ltu);
      logic w_cond;
      case (funct3[2:1])
         2'b00:   w_cond = zero;
         2'b10:   w_cond = negative;
         2'b11:   w_cond = ltu;
         default: w_cond = 1'b0;
      endcase
      return (w_cond ^ funct3[0]) & branch_legal(funct3);
   endfunction

endpackage

// File: rtl/rv_mc_watchdog.sv
// Bus-timeout watchdog: counts stalled cycles in a memory-wait state and flags the last allowed one.
// Latency: o_timeout is combinational from the count and the current mem_ready.
// Backpressure: none; a ready arriving in the limit cycle suppresses the timeout.
module rv_mc_watchdog
   import rv_mc_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_watch,
   input  logic i_mem_ready,
   input  logic i_clear,
   output logic o_timeout
);

   localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] r_cnt;

   // Wait counter: cleared on every state change, advances while a watched request stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_watch && !i_mem_ready && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_timeout = (TIMEOUT > 0) && i_watch && !i_mem_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I control FSM driving datapath selects, enables, traps and retirement count.
// Latency: 3-6 cycles per instruction with zero-wait memory, plus one per memory wait cycle.
// Backpressure: mem_req holds until mem_ready; MULDIV waits on md_done; stalls are bounded by the watchdog.
module rv_mc_ctrl
   import rv_mc_pkg::*;
#(
   parameter int M_EXT   = 0,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7_0,
   input  logic             zero,
   input  logic             negative,
   input  logic             ltu,
   input  logic             mem_ready,
   input  logic             md_done,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic             pc_trap,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       imm_src,
   output logic [1:0]       result_src,
   output logic             md_start,
   output logic             md_wb,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_cnt
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       w_cause_nxt;
   logic             w_watch;
   logic             w_timeout;
   logic             w_retire;
   logic             r_retired;
   logic [CNT_W-1:0] r_retired_cnt;
   logic [1:0]       r_trap_cause;

   assign w_watch = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);

   rv_mc_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_watch     (w_watch),
      .i_mem_ready (mem_ready),
      .i_clear     (w_state_nxt != r_state),
      .o_timeout   (w_timeout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode; everything not driven by a state stays 0
   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = CAUSE_NONE;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      pc_trap     = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      imm_src     = IMM_I;
      result_src  = RES_ALUOUT;
      md_start    = 1'b0;
      md_wb       = 1'b0;
      trap        = 1'b0;
      case (r_state)
         S_RESET: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            if (mem_ready) begin
               ir_write    = 1'b1;
               pc_write    = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            // Precompute the branch/jump target into ALUOut while the opcode is decoded
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
            case (op)
               OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
               OP_RTYPE:          w_state_nxt = S_EXECR;
               OP_ITYPE:          w_state_nxt = S_EXECI;
               OP_BRANCH:         w_state_nxt = S_BRANCH;
               OP_JAL:            w_state_nxt = S_JUMP;
               OP_JALR:           w_state_nxt = S_JALR;
               OP_LUI:            w_state_nxt = S_LUI;
               OP_AUIPC:          w_state_nxt = S_AUIPC;
               default: begin
                  w_state_nxt = S_TRAP;
                  w_cause_nxt = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            imm_src     = (op == OP_STORE) ? IMM_S : IMM_I;
            w_state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               w_state_nxt = S_MEMWB;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB: begin
            reg_write   = 1'b1;
            result_src  = RES_DATA;
            w_state_nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               w_state_nxt = S_FETCH;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
            if ((M_EXT != 0) && funct7_0) begin
               md_start    = 1'b1;
               w_state_nxt = S_MULDIV;
            end else begin
               w_state_nxt = S_ALUWB;
            end
         end
         S_EXECI: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            imm_src     = IMM_I;
            alu_op      = ALUOP_FUNCT;
            w_state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write   = 1'b1;
            result_src  = RES_ALUOUT;
            w_state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            // ALUOut still holds the target from DECODE; the ALU now compares rs1/rs2
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            if (!branch_legal(funct3)) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_ILLEGAL;
            end else begin
               pc_write    = branch_taken(funct3, zero, negative, ltu);
               w_state_nxt = S_FETCH;
            end
         end
         S_JALR: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            imm_src     = IMM_I;
            w_state_nxt = S_JUMP;
         end
         S_JUMP: begin
            // PC takes the target in ALUOut while OldPC+4 is computed for the link write
            pc_write    = 1'b1;
            result_src  = RES_ALUOUT;
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_FOUR;
            w_state_nxt = S_ALUWB;
         end
         S_LUI: begin
            reg_write   = 1'b1;
            result_src  = RES_IMM;
            imm_src     = IMM_U;
            w_state_nxt = S_FETCH;
         end
         S_AUIPC: begin
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_IMM;
            imm_src     = IMM_U;
            w_state_nxt = S_ALUWB;
         end
         S_MULDIV: begin
            if (md_done) begin
               w_state_nxt = S_MDWB;
            end
         end
         S_MDWB: begin
            reg_write   = 1'b1;
            md_wb       = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_TRAP: begin
            trap        = 1'b1;
            pc_write    = 1'b1;
            pc_trap     = 1'b1;
            w_state_nxt = S_FETCH;
         end
         default: begin
            w_state_nxt = S_RESET;
         end
      endcase
   end

   // An instruction completes when control returns to FETCH from anything but RESET or TRAP
   assign w_retire = (w_state_nxt == S_FETCH) && (r_state != S_FETCH) &&
                     (r_state != S_RESET) && (r_state != S_TRAP);

   // Trap cause captured on entry to TRAP and held until the next trap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trap_cause <= CAUSE_NONE;
      end else if (w_cause_nxt != CAUSE_NONE) begin
         r_trap_cause <= w_cause_nxt;
      end
   end

   // Retire pulse and wrapping retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired     <= 1'b0;
         r_retired_cnt <= '0;
      end else begin
         r_retired <= w_retire;
         if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
         end
      end
   end

   assign trap_cause    = r_trap_cause;
   assign instr_retired = r_retired;
   assign retired_cnt   = r_retired_cnt;

endmodule
